// File: rtl/i2s_stereo_transmitter_if.sv
// Sample-pair stream into the I2S transmitter holding buffer.
// A pair transfers on the clock edge where s_valid && s_ready; the producer
// holds data stable while s_valid is high, and s_ready never depends on s_valid.
interface i2s_stereo_transmitter_if #(
  parameter int SAMPLE_WIDTH = 24
);
  logic [SAMPLE_WIDTH-1:0] s_data_left;
  logic [SAMPLE_WIDTH-1:0] s_data_right;
  logic                    s_valid;
  logic                    s_ready;

  modport master (
    output s_data_left,
    output s_data_right,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data_left,
    input  s_data_right,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/i2s_stereo_transmitter.sv
// Stereo I2S / left-justified serialiser clocked by the bit clock, with a
// one-pair holding buffer, mute and underrun (zero or repeat) handling.
module i2s_stereo_transmitter #(
  parameter  int SAMPLE_WIDTH    = 24,
  parameter  int SLOT_WIDTH      = 32,
  parameter  int JUSTIFY         = 0,
  parameter  int UNDERRUN_REPEAT = 0,
  localparam int CW              = $clog2(2 * SLOT_WIDTH)
) (
  input  logic          serial_clk,
  input  logic          reset,
  i2s_stereo_transmitter_if.slave s_if,
  input  logic          mute,
  output logic          word_select,
  output logic          sound_bit_out,
  output logic [CW-1:0] bit_counter,
  output logic          underrun
);

  localparam logic [CW-1:0] LAST = CW'(2 * SLOT_WIDTH - 1);
  localparam logic [CW-1:0] SLOT = CW'(SLOT_WIDTH);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    buf_full_q, buf_full_d;
  logic [SAMPLE_WIDTH-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
  logic [SAMPLE_WIDTH-1:0] frm_l_q, frm_l_d, frm_r_q, frm_r_d;
  logic                    mute_q, mute_d;
  logic                    ws_q, ws_d;
  logic                    sdo_q, sdo_d;
  logic                    und_q, und_d;
  logic [CW-1:0]           ws_pos;
  logic                    load;
  logic                    hs;

  function automatic logic slot_of(input logic [CW-1:0] c);
    return c >= SLOT;
  endfunction

  function automatic logic data_bit(input logic [CW-1:0] c,
                                    input logic [SAMPLE_WIDTH-1:0] l,
                                    input logic [SAMPLE_WIDTH-1:0] r,
                                    input logic m);
    int p;
    logic [SAMPLE_WIDTH-1:0] s;
    logic [SAMPLE_WIDTH-1:0] sh;
    if (c < SLOT) begin
      p = int'(c);
      s = l;
    end else begin
      p = int'(c) - SLOT_WIDTH;
      s = r;
    end
    if (m || p >= SAMPLE_WIDTH) return 1'b0;
    sh = s << p;
    return sh[SAMPLE_WIDTH-1];
  endfunction

  assign load          = (cnt_q == LAST);
  assign s_if.s_ready  = !buf_full_q || load;
  assign hs            = s_if.s_valid && s_if.s_ready;

  always_comb begin
    cnt_d      = load ? '0 : cnt_q + CW'(1);
    buf_full_d = buf_full_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    frm_l_d    = frm_l_q;
    frm_r_d    = frm_r_q;
    mute_d     = mute_q;
    und_d      = 1'b0;

    if (hs) begin
      buf_l_d    = s_if.s_data_left;
      buf_r_d    = s_if.s_data_right;
      buf_full_d = 1'b1;
    end else if (load) begin
      buf_full_d = 1'b0;
    end

    // Frame boundary: the buffered pair (or underrun fill) becomes the next frame.
    if (load) begin
      mute_d = mute;
      if (buf_full_q) begin
        frm_l_d = buf_l_q;
        frm_r_d = buf_r_q;
      end else begin
        und_d = 1'b1;
        if (UNDERRUN_REPEAT == 0) begin
          frm_l_d = '0;
          frm_r_d = '0;
        end
      end
    end

    // In I2S mode word_select announces the slot one bit ahead of the MSB.
    ws_pos = (cnt_d == LAST) ? '0 : cnt_d + CW'(1);
    ws_d   = (JUSTIFY != 0) ? slot_of(cnt_d) : slot_of(ws_pos);
    sdo_d  = data_bit(cnt_d, frm_l_d, frm_r_d, mute_d);
  end

  always_ff @(posedge serial_clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      buf_full_q <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      frm_l_q    <= '0;
      frm_r_q    <= '0;
      mute_q     <= 1'b0;
      ws_q       <= 1'b0;
      sdo_q      <= 1'b0;
      und_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      buf_full_q <= buf_full_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      frm_l_q    <= frm_l_d;
      frm_r_q    <= frm_r_d;
      mute_q     <= mute_d;
      ws_q       <= ws_d;
      sdo_q      <= sdo_d;
      und_q      <= und_d;
    end
  end

  assign bit_counter   = cnt_q;
  assign word_select   = ws_q;
  assign sound_bit_out = sdo_q;
  assign underrun      = und_q;

endmodule

// File: doc/i2s_stereo_transmitter.md
# i2s_stereo_transmitter

Parametrised stereo I2S/left-justified serial transmitter driven directly by the serial bit clock. Accepts left/right sample pairs over a valid/ready handshake into a one-entry holding buffer, serialises them MSB-first into fixed-width slots, and generates `word_select` plus the frame `bit_counter`. Sits between the audio processing pipeline and the codec DAC pins. Adds configurable sample and slot width, framing mode, mute and underrun handling.

## Interface
Parameters:
- `SAMPLE_WIDTH`, 24: bits per channel sample; 8..SLOT_WIDTH.
- `SLOT_WIDTH`, 32: bit clocks per channel slot; >= 2. Frame = 2*SLOT_WIDTH.
- `JUSTIFY`, 0: 0 = I2S (WS leads MSB by one bit); 1 = left-justified (WS edge aligned with MSB).
- `UNDERRUN_REPEAT`, 0: 0 = send zeros on underrun; 1 = resend previous pair.

Ports:
- `serial_clk`  in  1  bit clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `s_data_left`  in  SAMPLE_WIDTH  left sample, two's complement.
- `s_data_right`  in  SAMPLE_WIDTH  right sample.
- `s_valid`  in  1  sample pair offered.
- `s_ready`  out  1  holding buffer can accept a pair.
- `mute`  in  1  force zero data; sampled at frame load.
- `word_select`  out  1  0 = left slot, 1 = right slot (per JUSTIFY timing).
- `sound_bit_out`  out  1  serial data.
- `bit_counter`  out  $clog2(2*SLOT_WIDTH)  position in frame, 0..2*SLOT_WIDTH-1.
- `underrun`  out  1  one-cycle pulse: frame started without a buffered pair.

## Operation
- Frame counter runs freely from reset release: 0, 1, …, 2*SLOT_WIDTH-1, wraps to 0.
- Slot position p = `bit_counter` mod SLOT_WIDTH; slot = left when `bit_counter` < SLOT_WIDTH.
- Data at position p: sample[SAMPLE_WIDTH-1-p] for p < SAMPLE_WIDTH, else 0 (trailing pad).
- `word_select`, JUSTIFY=1: equals slot (0 left, 1 right).
- `word_select`, JUSTIFY=0: equals slot of position `bit_counter`+1 (mod frame); toggles at counts SLOT_WIDTH-1 and 2*SLOT_WIDTH-1, one bit before MSB.
- Holding buffer (one pair): handshake when `s_valid` && `s_ready`. `s_ready` = buffer empty OR load cycle with buffer full.
- Load cycle = `bit_counter` == 2*SLOT_WIDTH-1. On load cycle:
  - buffer full: pair moves to frame registers, buffer empties unless a new handshake occurs the same cycle (then buffer refills).
  - buffer empty: underrun; next frame carries zeros (UNDERRUN_REPEAT=0) or previous pair (=1); `underrun` pulses during `bit_counter`==0 of that frame. A handshake in this same cycle fills the buffer for the following frame; no bypass.
  - `mute`=1: next frame data forced to zero; buffer still consumed normally; no underrun pulse caused by mute.
- First frame after reset: data zeros, no underrun pulse; previous pair for repeat mode = zeros.
- Reset mid-frame: all state cleared immediately; buffered pair discarded.

## Timing
- Reset values: `bit_counter`=0, `word_select`=0, `sound_bit_out`=0, `s_ready`=1, `underrun`=0; buffer empty; frame registers zero.
- `word_select`, `sound_bit_out`, `bit_counter`, `underrun` are registered and mutually aligned: in the cycle `bit_counter`=k, the other outputs describe position k.
- First counter step on first rising edge after `reset` deasserts: 0 -> 1.
- Latency: pair accepted while buffer empty and not in load cycle appears as left MSB at the next `bit_counter`=0. Worst case input-to-MSB ≤ 2*SLOT_WIDTH cycles.
- Sustained throughput: one pair per 2*SLOT_WIDTH cycles with no underrun if producer responds to `s_ready` within one frame.
- `s_ready` is combinational from buffer state and `bit_counter`; no combinational path from `s_valid`.

## Test plan
- Defaults, reset low 3 cycles then high, no input -> `bit_counter` 0..63 wrap, `word_select` high for counts 31..62, data all 0, `underrun` pulses at count 0 of frame 2 onward.
- Defaults, pair L=24'hA5F00F, R=24'h800001 offered before frame 2 -> at counts 0..23 bits of A5F00F MSB-first, counts 24..31 zero, counts 32..55 bits of 800001, no `underrun` that frame.
- JUSTIFY=1, SAMPLE_WIDTH=16, SLOT_WIDTH=16, L=16'h8001 -> `word_select` rises exactly at count 16 with right MSB; count 0 data 1, count 15 data 1.
- Back-to-back stream of 4 pairs, `s_valid` held high -> `s_ready` drops while buffer full, reasserts only at count 63; four consecutive frames carry pairs in order, no underrun.
- UNDERRUN_REPEAT=1, one pair L=24'h123456 then starvation -> following frames repeat 123456, `underrun`=1 at count 0 each; `mute`=1 at a load -> that frame zeros, no extra pulse.
- Assert `reset` low at count 40 with buffer full -> outputs return to reset values asynchronously; after release first frame is zeros, buffered pair lost.
